ov7670_capture: RTL
===================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 The module SHALL have parameter H_PIXELS, default 640, meaning active pixels per line.
REQ-002 The module SHALL have parameter V_LINES, default 480, meaning active lines per frame.
REQ-003 The module SHALL have parameter SKIP_FRAMES, default 2, meaning whole frames discarded after reset for camera start-up.
REQ-004 The module SHALL have port clk, input, 1, the single clock, which is the camera pixel clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-006 The module SHALL have port cam_vsync, input, 1, camera VSYNC, active-high between frames.
REQ-007 The module SHALL have port cam_href, input, 1, camera HREF, high while line bytes are valid.
REQ-008 The module SHALL have port cam_data, input, 8, camera byte bus.
REQ-009 The module SHALL have port full_fifo, input, 1, asynchronous-FIFO write-side full flag.
REQ-010 The module SHALL have port wr_en, output, 1, FIFO write strobe, one cycle per pixel.
REQ-011 The module SHALL have port dout, output, 16, RGB565 pixel: R[15:11], G[10:5], B[4:0].
REQ-012 The module SHALL have port frame_start, output, 1, one-cycle pulse at each accepted frame start.
REQ-013 The module SHALL have port overflow, output, 1, sticky flag indicating that a pixel was dropped because the FIFO was full.

Function
REQ-014 The module SHALL detect the frame start as the cycle in which cam_vsync is sampled low after having been sampled high in the previous cycle, using a 1-bit registered copy of cam_vsync.
REQ-015 The FSM SHALL use the states SKIP, WAIT_FRAME, BYTE_HI and BYTE_LO.
REQ-016 SKIP: the FSM SHALL count frame starts up to SKIP_FRAMES, then go to WAIT_FRAME; if SKIP_FRAMES is 0, it SHALL enter WAIT_FRAME directly.
REQ-017 WAIT_FRAME: on a frame start, the FSM SHALL pulse frame_start, clear overflow and the line counter, and go to BYTE_HI.
REQ-018 BYTE_HI: when cam_href is 1, the FSM SHALL latch cam_data into the high byte and go to BYTE_LO.
REQ-019 BYTE_LO: when cam_href is 1, the FSM SHALL latch cam_data into the low byte, mark the pixel ready, and return to BYTE_HI.
REQ-020 Write latency: dout and wr_en SHALL be registered; wr_en SHALL be 1 in the cycle after the low byte is sampled, with dout equal to {high byte, low byte}.
REQ-021 If full_fifo is 1 in the cycle in which a pixel becomes ready, the pixel SHALL be dropped (wr_en stays 0) and overflow SHALL be set; overflow SHALL hold until the next frame start or reset.
REQ-022 If cam_href falls while the FSM is in BYTE_LO, the orphan high byte SHALL be discarded and the FSM SHALL return to BYTE_HI.
REQ-023 On each falling edge of cam_href, the pixel counter SHALL clear and the line counter SHALL increment.
REQ-024 The pixel counter SHALL saturate at H_PIXELS; bytes beyond H_PIXELS pixels in a line SHALL not be written.
REQ-025 When the line counter reaches V_LINES, the FSM SHALL go to WAIT_FRAME, and further lines SHALL be ignored.
REQ-026 A cam_vsync rising edge seen in BYTE_HI or BYTE_LO SHALL abort the frame and move the FSM to WAIT_FRAME, with no write for a partial pixel.
REQ-027 The counter widths SHALL be $clog2(H_PIXELS+1) for the pixel counter and $clog2(V_LINES+1) for the line counter.

Reset
REQ-028 On reset, the FSM SHALL be in SKIP, and wr_en, frame_start, overflow, dout, all counters and the registered vsync SHALL be 0.
REQ-029 A reset assertion mid-line SHALL take effect immediately (asynchronously), and no write SHALL occur in the cycle after reset deasserts.

Configuration
REQ-030 With CAM_DECIMATE_EN defined, the module SHALL write only pixels whose pixel index and line index are both even, giving 320x240 from 640x480, and the skipped pixels SHALL not set overflow.
REQ-031 Without CAM_DECIMATE_EN, the module SHALL write every pixel.

Structure
REQ-032 Package cam_pkg SHALL hold the FSM state enum and the default H_PIXELS, V_LINES and SKIP_FRAMES constants.
REQ-033 Edge detection of cam_vsync and cam_href SHALL live in the sub-module cam_edge_det (one instance per signal), producing rise and fall pulses.

Verification
REQ-034 Reset then 2 vsync pulses -> no frame_start; 3rd vsync high-to-low -> frame_start=1 for exactly 1 cycle.
REQ-035 Line bytes 0xF8,0x00,0x07,0xE0 -> wr_en pulses twice with dout=0xF800 then dout=0x07E0, each one cycle after its low byte.
REQ-036 full_fifo=1 during the 3rd pixel -> that pixel is not written and overflow=1 until the next frame_start, then overflow=0.
REQ-037 cam_href falls after 3 bytes -> 1 write only; the next line starts a fresh pixel on its first byte.
REQ-038 Vsync rises after 100 lines -> no further writes, state WAIT_FRAME, next frame captures normally; with CAM_DECIMATE_EN, a 640x480 frame -> exactly 76800 writes.

Source files
------------

// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cam_pkg
// Brief   : Shared FSM state encoding and default geometry for the OV7670
//           capture block.
// Rev     : 1.0
// ============================================================================
package cam_pkg;

  typedef enum logic [1:0] {
    SKIP       = 2'd0,
    WAIT_FRAME = 2'd1,
    BYTE_HI    = 2'd2,
    BYTE_LO    = 2'd3
  } cam_state_t;

  localparam int c_default_h_pixels    = 640;
  localparam int c_default_v_lines     = 480;
  localparam int c_default_skip_frames = 2;

endpackage
`default_nettype wire

// File: rtl/cam_edge_det.sv
`default_nettype none
// ============================================================================
// Module  : cam_edge_det
// Brief   : Registers one camera strobe and flags its rising/falling edges
//           against the live input.
// Rev     : 1.0
// ============================================================================
module cam_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic r_sig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= sig;
    end
  end

  assign rise = sig & ~r_sig_d;
  assign fall = ~sig & r_sig_d;

endmodule
`default_nettype wire

// File: rtl/ov7670_capture.sv
`default_nettype none
// ============================================================================
// Module  : ov7670_capture
// Brief   : Assembles OV7670 byte pairs into RGB565 FIFO writes; defining
//           CAM_DECIMATE_EN keeps only even pixels on even lines.
// Rev     : 1.0
// ============================================================================
module ov7670_capture
  import cam_pkg::*;
#(
  parameter int H_PIXELS    = c_default_h_pixels,
  parameter int V_LINES     = c_default_v_lines,
  parameter int SKIP_FRAMES = c_default_skip_frames
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        full_fifo,
  output logic        wr_en,
  output logic [15:0] dout,
  output logic        frame_start,
  output logic        overflow
);

  localparam int c_pix_w  = $clog2(H_PIXELS + 1);
  localparam int c_line_w = $clog2(V_LINES + 1);
  localparam int c_skip_w = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  localparam logic [c_pix_w-1:0]  c_pix_max   = c_pix_w'(H_PIXELS);
  localparam logic [c_line_w-1:0] c_line_last = c_line_w'(V_LINES - 1);
  localparam logic [c_skip_w-1:0] c_skip_last = c_skip_w'(SKIP_FRAMES - 1);

  cam_state_t          r_state;
  logic [c_skip_w-1:0] r_skip_cnt;
  logic [c_pix_w-1:0]  r_pix_cnt;
  logic [c_line_w-1:0] r_line_cnt;
  logic [7:0]          r_hi;

  logic w_vs_rise;
  logic w_vs_fall;
  logic w_href_rise;
  logic w_href_fall;
  logic w_keep;

  cam_edge_det u_vsync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (cam_vsync),
    .rise  (w_vs_rise),
    .fall  (w_vs_fall)
  );

  cam_edge_det u_href_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (cam_href),
    .rise  (w_href_rise),
    .fall  (w_href_fall)
  );

`ifdef CAM_DECIMATE_EN
  assign w_keep = ~r_pix_cnt[0] & ~r_line_cnt[0];
`else
  assign w_keep = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SKIP;
      r_skip_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_line_cnt  <= '0;
      r_hi        <= '0;
      wr_en       <= 1'b0;
      dout        <= '0;
      frame_start <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      case (r_state)
        SKIP: begin
          if (SKIP_FRAMES == 0) begin
            r_state <= WAIT_FRAME;
          end else if (w_vs_fall) begin
            if (r_skip_cnt == c_skip_last) begin
              r_state <= WAIT_FRAME;
            end else begin
              r_skip_cnt <= r_skip_cnt + 1'b1;
            end
          end
        end
        WAIT_FRAME: begin
          if (w_vs_fall) begin
            frame_start <= 1'b1;
            overflow    <= 1'b0;
            r_line_cnt  <= '0;
            r_pix_cnt   <= '0;
            r_state     <= BYTE_HI;
          end
        end
        BYTE_HI, BYTE_LO: begin
          // An early vsync aborts the frame before any line/pixel bookkeeping.
          if (w_vs_rise) begin
            r_state <= WAIT_FRAME;
          end else if (w_href_fall) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= r_line_cnt + 1'b1;
            r_state    <= (r_line_cnt == c_line_last) ? WAIT_FRAME : BYTE_HI;
          end else if (cam_href) begin
            if (r_state == BYTE_HI) begin
              if (w_href_rise) begin
                r_pix_cnt <= '0;
              end
              r_hi    <= cam_data;
              r_state <= BYTE_LO;
            end else begin
              r_state <= BYTE_HI;
              if (r_pix_cnt != c_pix_max) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
                if (w_keep) begin
                  if (full_fifo) begin
                    overflow <= 1'b1;
                  end else begin
                    wr_en <= 1'b1;
                    dout  <= {r_hi, cam_data};
                  end
                end
              end
            end
          end
        end
        default: r_state <= SKIP;
      endcase
    end
  end

endmodule
`default_nettype wire
